// File: rtl/cicn_pkg.sv
// Shared definitions for the cicn_decim CIC decimator: datapath width,
// ratio clamping and the digital monitor select encoding.
package cicn_pkg;

  localparam int unsigned MON_SEL_W          = 4;
  localparam int unsigned WARM_W             = 3;
  localparam int unsigned MON_SEL_INTEG_BASE = 0;

  // Datapath wide enough to hold R^ORDER at the largest ratio without loss.
  function automatic int unsigned cic_out_width(input int unsigned order,
                                                input int unsigned max_log2);
    return order * max_log2 + 1;
  endfunction

  // Ratio 0 means "no decimation below 2"; anything above the build maximum clamps.
  function automatic logic [3:0] ratio_clamp(input logic [3:0] r,
                                             input int unsigned max_log2);
    if (r == 4'd0) return 4'd1;
    if (32'(r) > max_log2) return 4'(max_log2);
    return r;
  endfunction

  function automatic int unsigned mon_sel_comb_base(input int unsigned order);
    return order;
  endfunction

  function automatic int unsigned mon_sel_counter(input int unsigned order);
    return 2 * order;
  endfunction

  function automatic int unsigned mon_sel_status(input int unsigned order);
    return 2 * order + 1;
  endfunction

endpackage

// File: rtl/cicn_comb_stage.sv
// One comb (differentiator) section: y = x - x_prev, delay register advances
// only on decimation events. Subtraction wraps modulo 2^W.
module cicn_comb_stage
  import cicn_pkg::*;
#(
  parameter int unsigned W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o,
  output logic [W-1:0] dly_o
);

  logic [W-1:0] dly_q, dly_d;

  assign y_o   = x_i - dly_q;
  assign dly_o = dly_q;

  // Next delay value: cleared on ratio change, captures input on an event.
  always_comb begin
    dly_d = dly_q;
    if (clr_i)     dly_d = '0;
    else if (en_i) dly_d = x_i;
  end

  // Delay register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dly_q <= '0;
    else       dly_q <= dly_d;
  end

endmodule

// File: rtl/cicn_decim.sv
// N-th order CIC decimator for a 1-bit modulator stream with runtime
// power-of-two ratio, warm-up suppression and full-scale normalised output.
// Optional: define CIC_DIGITAL_MONITOR_EN to enable the registered monitor mux;
// otherwise digital_monitor is tied to 0.
module cicn_decim
  import cicn_pkg::*;
#(
  parameter  int unsigned ORDER          = 3,
  parameter  int unsigned MAX_RATIO_LOG2 = 6,
  localparam int unsigned OUT_WIDTH      = cic_out_width(ORDER, MAX_RATIO_LOG2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 in_valid,
  input  logic [3:0]           ratio_log2,
  input  logic [3:0]           digital_monitor_sel,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] digital_monitor
);

  localparam int unsigned CW = MAX_RATIO_LOG2;

  logic [3:0]           eff_now, eff_cur, ratio_q;
  logic                 ratio_ok_q, ratio_chg;
  logic [CW-1:0]        cnt_q, cnt_last;
  logic                 dec_ev, ev1_q, ev2_q;
  logic [OUT_WIDTH-1:0] integ_q [ORDER];
  logic [OUT_WIDTH-1:0] integ_d [ORDER];
  logic [OUT_WIDTH-1:0] comb_res_q, out_q, out_d;
  logic                 out_valid_q;
  logic [WARM_W-1:0]    warm_q;
`ifdef CIC_DIGITAL_MONITOR_EN
  logic [OUT_WIDTH-1:0] comb_dly [ORDER];
  logic [OUT_WIDTH-1:0] mon_q, mon_d;
`endif

  // Ratio register is "unloaded" out of reset so the first edge adopts the
  // live ratio without being treated as a change.
  assign eff_now   = ratio_clamp(ratio_log2, MAX_RATIO_LOG2);
  assign eff_cur   = ratio_ok_q ? ratio_q : eff_now;
  assign ratio_chg = ratio_ok_q && (eff_now != ratio_q);
  assign cnt_last  = CW'((32'd1 << eff_cur) - 32'd1);
  assign dec_ev    = in_valid && !ratio_chg && (cnt_q == cnt_last);

  // Effective-ratio register, sampled every clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ratio_q    <= '0;
      ratio_ok_q <= 1'b0;
    end else begin
      ratio_q    <= eff_now;
      ratio_ok_q <= 1'b1;
    end
  end

  // Integrator cascade: each stage accumulates the already-updated value of
  // the one before it, so the last stage includes the current sample.
  always_comb begin
    logic [OUT_WIDTH-1:0] acc;
    acc = OUT_WIDTH'(in);
    for (int unsigned i = 0; i < ORDER; i++) begin
      acc        = integ_q[i] + acc;
      integ_d[i] = acc;
    end
  end

  // Integrators and decimation counter advance only on accepted samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ORDER; i++) integ_q[i] <= '0;
      cnt_q <= '0;
    end else if (ratio_chg) begin
      for (int unsigned i = 0; i < ORDER; i++) integ_q[i] <= '0;
      cnt_q <= '0;
    end else if (in_valid) begin
      for (int unsigned i = 0; i < ORDER; i++) integ_q[i] <= integ_d[i];
      cnt_q <= dec_ev ? '0 : cnt_q + CW'(1);
    end
  end

  for (genvar i = 0; i < ORDER; i++) begin : g_comb
    logic [OUT_WIDTH-1:0] x, y, dly;
    if (i == 0) begin : g_head
      assign x = integ_q[ORDER-1];
    end else begin : g_link
      assign x = g_comb[i-1].y;
    end
    cicn_comb_stage #(.W(OUT_WIDTH)) u_comb (
      .clk   (clk),
      .reset (reset),
      .clr_i (ratio_chg),
      .en_i  (ev1_q),
      .x_i   (x),
      .y_o   (y),
      .dly_o (dly)
    );
`ifdef CIC_DIGITAL_MONITOR_EN
    assign comb_dly[i] = dly;
`else
    logic unused_dly;
    assign unused_dly = ^dly;
`endif
  end

  // Rescale so a constant-1 input reads 2^(OUT_WIDTH-1) at every ratio.
  assign out_d = comb_res_q << (ORDER * (MAX_RATIO_LOG2 - 32'(eff_cur)));

  // Event pipeline: comb result one edge after the event, output the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev1_q       <= 1'b0;
      ev2_q       <= 1'b0;
      comb_res_q  <= '0;
      warm_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (ratio_chg) begin
        ev1_q      <= 1'b0;
        ev2_q      <= 1'b0;
        comb_res_q <= '0;
        warm_q     <= '0;
      end else begin
        ev1_q <= dec_ev;
        ev2_q <= ev1_q;
        if (ev1_q) comb_res_q <= g_comb[ORDER-1].y;
        if (ev2_q) begin
          if (32'(warm_q) < ORDER) begin
            warm_q <= warm_q + WARM_W'(1);
          end else begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef CIC_DIGITAL_MONITOR_EN
  // Monitor source select.
  always_comb begin
    mon_d = '0;
    for (int unsigned i = 0; i < ORDER; i++) begin
      if (32'(digital_monitor_sel) == MON_SEL_INTEG_BASE + i) mon_d = integ_q[i];
      if (32'(digital_monitor_sel) == mon_sel_comb_base(ORDER) + i) mon_d = comb_dly[i];
    end
    if (32'(digital_monitor_sel) == mon_sel_counter(ORDER)) mon_d = OUT_WIDTH'(cnt_q);
    if (32'(digital_monitor_sel) == mon_sel_status(ORDER))  mon_d = OUT_WIDTH'({warm_q, eff_cur});
  end

  // Monitor register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mon_q <= '0;
    else       mon_q <= mon_d;
  end

  assign digital_monitor = mon_q;
`else
  logic unused_sel;
  assign unused_sel      = ^digital_monitor_sel;
  assign digital_monitor = '0;
`endif

endmodule

// File: tb/tb_cicn_decim.sv
// Directed bench for cicn_decim (ORDER=3, MAX_RATIO_LOG2=6, 19-bit output).
module tb_cicn_decim;

  localparam int W  = 19;
  localparam logic [63:0] FS = 64'd262144;

  logic         clk = 1'b0;
  logic         reset, in, in_valid;
  logic [3:0]   ratio_log2, sel;
  logic [W-1:0] out, mon;
  logic         out_valid;

  int           n_vec = 0;
  int           n_err = 0;
  int           tcnt  = 0;
  int           pulse_t[$];
  logic [W-1:0] pulse_v[$];
  logic [63:0]  mexp [16];

  always #5 clk = ~clk;

  cicn_decim #(.ORDER(3), .MAX_RATIO_LOG2(6)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in                  (in),
    .in_valid            (in_valid),
    .ratio_log2          (ratio_log2),
    .digital_monitor_sel (sel),
    .out                 (out),
    .out_valid           (out_valid),
    .digital_monitor     (mon)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: hold inputs; 1: in alternates 0,1; 2: in_valid one clk in four
  task automatic run_rec(input int n, input int mode);
    for (int j = 0; j < n; j++) begin
      if (mode == 1) in = tcnt[0];
      if (mode == 2) in_valid = ((tcnt % 4) == 0);
      tick();
      tcnt++;
      if (out_valid) begin
        pulse_t.push_back(tcnt);
        pulse_v.push_back(out);
      end
    end
  endtask

  task automatic chk_pulses(input string tag, input int n, input int t0, input int per,
                            input logic [W-1:0] v);
    chk({tag, "_count"}, 64'(pulse_t.size()), 64'(n));
    for (int i = 0; i < n && i < pulse_t.size(); i++) begin
      chk({tag, "_time"}, 64'(pulse_t[i]), 64'(t0 + i * per));
      chk({tag, "_value"}, 64'(pulse_v[i]), 64'(v));
    end
    pulse_t.delete();
    pulse_v.delete();
  endtask

  task automatic restart(input logic [3:0] r);
    reset = 1'b1;
    ratio_log2 = r;
    in = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tcnt = 0;
    pulse_t.delete();
    pulse_v.delete();
  endtask

  function automatic logic [63:0] icube(input logic [63:0] s);
    return s * (s + 1) * (s + 2) / 6;
  endfunction

  initial begin
    int t0;
    logic [63:0] mask, i64, i128, i192;
    mask = 64'h7FFFF;

    // Reset held with a live input stream
    reset = 1'b1; in = 1'b1; in_valid = 1'b1; ratio_log2 = 4'd6; sel = 4'd0;
    #2;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_monitor", 64'(mon), 64'd0);
    end
    reset = 1'b0;
    tcnt = 0;

    // R=64, constant 1: 4th decimated result at tick 256+2, then every 64
    run_rec(386, 0);
    chk_pulses("r64", 3, 258, 64, FS);

    // Switch to R=4: change edge at 387, 3 results discarded, first valid at 405
    ratio_log2 = 4'd2;
    run_rec(27, 0);
    chk_pulses("switch_r4", 3, 405, 4, FS);

    // Asynchronous reset clears outputs without a clock edge
    chk("pre_arst_out", 64'(out), FS);
    reset = 1'b1;
    #1;
    chk("arst_out", 64'(out), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);

    // R=8, alternating 0/1: half scale every 8 clk after warm-up
    restart(4'd3);
    run_rec(50, 1);
    chk_pulses("alt_r8", 3, 34, 8, W'(131072));

    // ratio_log2=9 clamps to 6; stall after 200 samples and read the monitor
    restart(4'd9);
    in = 1'b1;
    run_rec(200, 0);
    in_valid = 1'b0;
    chk_pulses("clamp_warmup", 0, 0, 0, '0);

    i64 = icube(64); i128 = icube(128); i192 = icube(192);
    for (int s = 0; s < 16; s++) mexp[s] = 64'd0;
`ifdef CIC_DIGITAL_MONITOR_EN
    mexp[0] = 64'd200;
    mexp[1] = 64'd20100;
    mexp[2] = icube(200) & mask;
    mexp[3] = i192 & mask;
    mexp[4] = (i192 - i128) & mask;
    mexp[5] = ((i192 - i128) - (i128 - i64)) & mask;
    mexp[6] = 64'd8;
    mexp[7] = 64'd54;
`endif
    for (int s = 0; s < 10; s++) begin
      sel = (s == 9) ? 4'd15 : 4'(s);
      run_rec(1, 0);
      chk($sformatf("monitor_sel%0d", sel), 64'(mon), mexp[sel]);
    end
    chk_pulses("stall_quiet", 0, 0, 0, '0);

    // Resume: 56 more samples reach the 256th, output 2 clk later
    t0 = tcnt;
    in_valid = 1'b1;
    run_rec(60, 0);
    chk_pulses("clamp_latency", 1, t0 + 58, 64, FS);

    // R=64 with in_valid one clk in four: period 256 clk
    restart(4'd6);
    run_rec(1280, 2);
    chk_pulses("sparse_valid", 2, 1023, 256, FS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cicn_decim.md
# cicn_decim

Parametrised N-th order CIC decimation filter for 1-bit sigma-delta bitstreams. It is the successor to the fixed third-order CIC in the eChip65 signal chain and sits directly behind the modulator. It adds compile-time order, runtime power-of-two decimation ratio, an input sample strobe, full-scale-normalised output with a valid pulse, and a selectable digital monitor.

## Interface
- ORDER, 3, number of integrator/comb stage pairs (1..6)
- MAX_RATIO_LOG2, 6, log2 of largest decimation ratio (1..8)
- OUT_WIDTH (localparam), ORDER*MAX_RATIO_LOG2+1, output and datapath width
- clk  input  1  system clock (5 MHz nominal)
- reset  input  1  asynchronous, active-high reset
- in  input  1  modulator bit; 0 adds 0, 1 adds +1
- in_valid  input  1  qualifies `in`; at most one sample per clk
- ratio_log2  input  4  log2 of decimation ratio R
- digital_monitor_sel  input  4  monitor source select
- out  output  OUT_WIDTH  decimated sample, unsigned, full-scale normalised
- out_valid  output  1  one-cycle pulse marking new `out`
- digital_monitor  output  OUT_WIDTH  selected internal state

## Operation
- Effective ratio: ratio_log2=0 is treated as 1; values above MAX_RATIO_LOG2 clamp to MAX_RATIO_LOG2. R = 2^effective.
- Integrators: ORDER cascaded accumulators, OUT_WIDTH bits each, modular (wrap-around) arithmetic. Wrapping is required and must not saturate. They update only on in_valid.
- Decimation counter: counts accepted samples 0..R-1. The in_valid sample with count==R-1 is the decimation event, and the counter returns to 0.
- Combs: ORDER differentiators (x[n]-x[n-1], modular), clocked only by decimation events.
- Normalisation: the comb result is shifted left by ORDER*(MAX_RATIO_LOG2-effective). A constant input of 1 then yields 2^(OUT_WIDTH-1) at every ratio.
- Warm-up: after reset or a ratio change, the first ORDER decimated results are discarded (no out_valid, `out` unchanged). The (ORDER+1)th result is the first valid one.
- Ratio change:
  - ratio_log2 is sampled every clk.
  - Any change in effective ratio clears the integrators, combs, counter and warm-up count on the next edge.
  - `out` keeps its last value.
  - in_valid in that same cycle is ignored.
- Output overflow cannot occur; the full-scale value fits OUT_WIDTH exactly.

## Timing
- Reset: out=0, out_valid=0, digital_monitor=0, all internal state 0, and the ratio register loads the current effective ratio.
- Decimation event sampled at edge k: last integrator updated at k, comb chain registered at k+1, out/out_valid at k+2. Latency is 2 clk.
- out_valid is high for exactly 1 clk. Back-to-back pulses are possible only at R=2 with continuous in_valid (period 2 clk).
- in_valid low stalls everything except an in-flight comb/output stage.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous). Warm-up restarts on release.

## Configuration
- CIC_DIGITAL_MONITOR_EN defined: digital_monitor is registered (1 clk after sel/state change) with the following sources:
  - sel 0..ORDER-1: integrator i
  - sel ORDER..2*ORDER-1: comb delay register i
  - sel 2*ORDER: decimation counter
  - sel 2*ORDER+1: {warm-up count, effective ratio_log2} zero-extended
  - other sel values: 0
- Not defined: digital_monitor is tied to 0, and the port is still present.

## Structure
- Package cicn_pkg holds:
  - the monitor-select encoding constants
  - the ratio clamp function
  - the OUT_WIDTH computation function
- One sub-module, cicn_comb_stage (registered differentiator with enable), instantiated ORDER times via generate. Integrators are inline.

## Test plan
All scenarios use ORDER=3, MAX_RATIO_LOG2=6 (OUT_WIDTH=19).
- Reset with in=1, in_valid=1 held -> out=0, out_valid=0, digital_monitor=0 throughout reset.
- ratio_log2=6, in=1, in_valid=1 continuous from reset release -> first out_valid at decimated sample 4, out=262144. out_valid then every 64 clk with value 262144.
- ratio_log2=3, alternating in=0,1 continuous -> after warm-up, out=131072 every 8 clk. ratio_log2=9 behaves identically to 6.
- ratio_log2=6, in=1, in_valid high 1 clk in 4 -> out_valid period 256 clk, out=262144. Latency is 2 clk from the 64th accepted sample.
- Mid-run switch 6->2 -> no out_valid for the next 3 decimated results (12 samples), then out=262144 every 4 clk. Reset mid-run -> out=0 immediately.
- Macro defined, sel 0..8 swept at steady state -> monitor matches integrator/comb/counter models; sel 15 -> 0. Macro undefined -> monitor stays 0.
